// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data RAM with req/ack handshake and sub-word load extension.
// Latency: ack LATENCY+1 cycles after accept (1 on error); busy stalls the pipeline, req while busy is dropped.
module data_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int AW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  output logic          busy,
  output logic          ack,
  output logic          err,
  output logic [31:0]   rdata
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept, load;

  logic          we_q, sext_q, err_q;
  logic [IW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;

  logic [7:0]    mem [DEPTH];

  // Request validity: alignment, size encoding and the last touched byte must fit the array
  logic [2:0]    nbytes;
  logic [AW:0]   last_addr;
  logic          req_bad;

  always_comb begin
    nbytes = 3'd4;
    case (size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    last_addr = {1'b0, addr} + (AW+1)'(nbytes) - (AW+1)'(1);
    req_bad   = (size == 2'b11) ||
                (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00) ||
                (last_addr >= (AW+1)'(DEPTH));
  end

  // Load path reads straight from the inputs when LATENCY = 0 completes from IDLE
  logic [IW-1:0] ld_ix;
  logic [1:0]    ld_size;
  logic          ld_sext;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   ld_val;

  always_comb begin
    ld_ix   = (state == IDLE) ? addr[IW-1:0] : addr_q;
    ld_size = (state == IDLE) ? size : size_q;
    ld_sext = (state == IDLE) ? sign_ext : sext_q;
    b0 = mem[ld_ix];
    b1 = mem[ld_ix + IW'(1)];
    b2 = mem[ld_ix + IW'(2)];
    b3 = mem[ld_ix + IW'(3)];
    case (ld_size)
      2'b00:   ld_val = {{24{ld_sext & b0[7]}}, b0};
      2'b01:   ld_val = {{16{ld_sext & b0[7]}}, b0, b1};
      default: ld_val = {b0, b1, b2, b3};
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (req_bad) begin
            state_nxt = DONE;
          end else if (LATENCY == 0) begin
            state_nxt = DONE;
            load      = !we;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          load      = !we_q;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
      rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) err_q <= req_bad;
      if (load)   rdata <= ld_val;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      addr_q  <= addr[IW-1:0];
      wdata_q <= wdata;
      size_q  <= size;
      sext_q  <= sign_ext;
    end
  end

  // Store commits on the edge leaving DONE; a coincident reset cancels it
  always_ff @(posedge clk) begin
    if (!reset && state == DONE && we_q && !err_q) begin
      case (size_q)
        2'b00: mem[addr_q] <= wdata_q[7:0];
        2'b01: begin
          mem[addr_q]          <= wdata_q[15:8];
          mem[addr_q + IW'(1)] <= wdata_q[7:0];
        end
        default: begin
          mem[addr_q]          <= wdata_q[31:24];
          mem[addr_q + IW'(1)] <= wdata_q[23:16];
          mem[addr_q + IW'(2)] <= wdata_q[15:8];
          mem[addr_q + IW'(3)] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign ack  = (state == DONE);
  assign err  = ack & err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: LATENCY=2 instance for the main sequence, LATENCY=0 instance for fast-path timing.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req, we, sign_ext;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        busy, ack, err;
  logic [31:0] rdata;

  logic        req_z, we_z, sext_z;
  logic [31:0] addr_z, wdata_z;
  logic [1:0]  size_z;
  logic        busy_z, ack_z, err_z;
  logic [31:0] rdata_z;

  data_mem_ctrl #(.DEPTH(256), .AW(32), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .sign_ext(sign_ext), .busy(busy), .ack(ack), .err(err), .rdata(rdata)
  );

  data_mem_ctrl #(.DEPTH(256), .AW(32), .LATENCY(0)) dut_z (
    .clk(clk), .reset(reset), .req(req_z), .we(we_z), .addr(addr_z), .wdata(wdata_z),
    .size(size_z), .sign_ext(sext_z), .busy(busy_z), .ack(ack_z), .err(err_z), .rdata(rdata_z)
  );

  int checks = 0;
  int errors = 0;
  int acks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on the LATENCY=2 instance: checks cycles-to-ack, err, rdata, then return to idle
  task automatic run(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic sx, input int exp_n, input logic exp_err,
                     input logic [31:0] exp_rd);
    int n;
    we = w; addr = a; wdata = d; size = s; sign_ext = sx; req = 1'b1; n = 0;
    do begin
      step();
      req = 1'b0;
      n++;
    end while (!ack && n < 20);
    chk({tag, "/lat"}, 32'(n), 32'(exp_n));
    chk({tag, "/err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "/rdata"}, rdata, exp_rd);
    step();
    chk({tag, "/idle"}, {30'b0, busy, ack}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    req = 0; we = 0; addr = 0; wdata = 0; size = 0; sign_ext = 0;
    req_z = 0; we_z = 0; addr_z = 0; wdata_z = 0; size_z = 0; sext_z = 0;
    step();
    step();
    chk("rst_busy",  {31'b0, busy}, 32'h0);
    chk("rst_ack",   {31'b0, ack},  32'h0);
    chk("rst_err",   {31'b0, err},  32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    step();

    run("wr_w4",   1'b1, 4, 32'hDEADBEEF, 2'b10, 1'b0, 3, 1'b0, 32'h00000000);
    run("rd_w4",   1'b0, 4, 32'h0, 2'b10, 1'b0, 3, 1'b0, 32'hDEADBEEF);
    run("rd_b4s",  1'b0, 4, 32'h0, 2'b00, 1'b1, 3, 1'b0, 32'hFFFFFFDE);
    run("rd_b4u",  1'b0, 4, 32'h0, 2'b00, 1'b0, 3, 1'b0, 32'h000000DE);
    run("rd_h6u",  1'b0, 6, 32'h0, 2'b01, 1'b0, 3, 1'b0, 32'h0000BEEF);
    run("rd_h4s",  1'b0, 4, 32'h0, 2'b01, 1'b1, 3, 1'b0, 32'hFFFFDEAD);
    run("rd_b7s",  1'b0, 7, 32'h0, 2'b00, 1'b1, 3, 1'b0, 32'hFFFFFFEF);

    run("er_w5",   1'b1, 5,   32'h11111111, 2'b10, 1'b0, 1, 1'b1, 32'hFFFFFFEF);
    run("er_h3",   1'b0, 3,   32'h0, 2'b01, 1'b0, 1, 1'b1, 32'hFFFFFFEF);
    run("er_sz3",  1'b0, 0,   32'h0, 2'b11, 1'b0, 1, 1'b1, 32'hFFFFFFEF);
    run("er_w254", 1'b0, 254, 32'h0, 2'b10, 1'b0, 1, 1'b1, 32'hFFFFFFEF);
    run("er_b256", 1'b1, 256, 32'h99999999, 2'b00, 1'b0, 1, 1'b1, 32'hFFFFFFEF);
    run("rd_w4b",  1'b0, 4, 32'h0, 2'b10, 1'b0, 3, 1'b0, 32'hDEADBEEF);

    run("wr_w252",  1'b1, 252, 32'h01020304, 2'b10, 1'b0, 3, 1'b0, 32'hDEADBEEF);
    run("rd_w252",  1'b0, 252, 32'h0, 2'b10, 1'b0, 3, 1'b0, 32'h01020304);
    run("rd_b255u", 1'b0, 255, 32'h0, 2'b00, 1'b0, 3, 1'b0, 32'h00000004);

    // Second req pulse during WAIT must be dropped
    run("wr_w12", 1'b1, 12, 32'hA5A5A5A5, 2'b10, 1'b0, 3, 1'b0, 32'h00000004);
    we = 1; addr = 8; wdata = 32'h00001234; size = 2'b01; sign_ext = 0; req = 1;
    acks = 0;
    step();
    req = 0;
    if (ack) acks++;
    we = 1; addr = 12; wdata = 32'hFFFFFFFF; size = 2'b10; req = 1;
    step();
    req = 0;
    if (ack) acks++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack) acks++;
    end
    chk("one_ack", 32'(acks), 32'd1);
    run("rd_b8",  1'b0, 8,  32'h0, 2'b00, 1'b0, 3, 1'b0, 32'h00000012);
    run("rd_b9",  1'b0, 9,  32'h0, 2'b00, 1'b0, 3, 1'b0, 32'h00000034);
    run("rd_w12", 1'b0, 12, 32'h0, 2'b10, 1'b0, 3, 1'b0, 32'hA5A5A5A5);

    // Reset during WAIT aborts the store
    run("wr_w16", 1'b1, 16, 32'h55667788, 2'b10, 1'b0, 3, 1'b0, 32'hA5A5A5A5);
    we = 1; addr = 16; wdata = 32'hCAFEF00D; size = 2'b10; req = 1;
    step();
    req = 0;
    chk("abort_busy_pre", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy",  {31'b0, busy}, 32'h0);
    chk("abort_ack",   {31'b0, ack},  32'h0);
    chk("abort_err",   {31'b0, err},  32'h0);
    chk("abort_rdata", rdata, 32'h0);
    step();
    run("rd_w16", 1'b0, 16, 32'h0, 2'b10, 1'b0, 3, 1'b0, 32'h55667788);

    // LATENCY=0: ack right after accept, back-to-back accepts every 2 cycles with req held
    we_z = 1; addr_z = 0; wdata_z = 32'h0BADF00D; size_z = 2'b10; sext_z = 0; req_z = 1;
    step();
    chk("z_wr_ack",  {31'b0, ack_z},  32'h1);
    chk("z_wr_err",  {31'b0, err_z},  32'h0);
    chk("z_wr_busy", {31'b0, busy_z}, 32'h1);
    we_z = 0;
    step();
    chk("z_gap_ack",  {31'b0, ack_z},  32'h0);
    chk("z_gap_busy", {31'b0, busy_z}, 32'h0);
    step();
    chk("z_rd_ack",   {31'b0, ack_z}, 32'h1);
    chk("z_rd_rdata", rdata_z, 32'h0BADF00D);
    req_z = 0;
    step();
    chk("z_rd_done", {31'b0, ack_z}, 32'h0);
    size_z = 2'b11; req_z = 1;
    step();
    req_z = 0;
    chk("z_er_ack",   {31'b0, ack_z}, 32'h1);
    chk("z_er_err",   {31'b0, err_z}, 32'h1);
    chk("z_er_rdata", rdata_z, 32'h0BADF00D);
    step();
    chk("z_er_done", {31'b0, ack_z}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
